psum_accumulator: RTL and testbench

- Parametrised partial-sum accumulator for the conv datapath.
- Sums LANES-wide input streams over NCHNL input channels into an internal DEPTH-entry buffer, one entry per output pixel.
- After the last channel it drains the buffer to the bus with a valid/ready handshake.
- Sits between the MAC array output and the bus write-back master.

---
 rtl/psum_accumulator.sv | 200 ++++++++++++++++++++
 tb/tb_psum_accumulator.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: adds NCHNL channels of LANES-wide beats into a
// DEPTH-entry buffer, then drains the buffer with a valid/ready handshake.
module psum_accumulator #(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int DEPTH = 3136,
  parameter int NCHNL = 8,
  parameter int AW    = 12,
  parameter bit SAT   = 1'b1,
  parameter bit RELU  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LANES*DW-1:0] data_i,
  input  logic                valid_i,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] data_o,
  output logic                valid_o,
  output logic [AW-1:0]       addr_o,
  output logic                last_o,
  output logic                busy,
  output logic                conv_done,
  output logic                err_o
);
  localparam int W  = LANES * DW;
  localparam int CW = (NCHNL > 1) ? $clog2(NCHNL) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CHN  = CW'(NCHNL - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] chn;
  logic          flush_cnt;
  logic          rd_all;

  logic          s1_valid, s1_first;
  logic [W-1:0]  s1_data;
  logic [AW-1:0] s1_addr;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_data;

  logic          rd_pend;
  logic [AW-1:0] rd_addr_q;
  logic          pf_valid;
  logic [W-1:0]  pf_data;
  logic [AW-1:0] pf_addr;

  logic          accept, wr_en, rd_en, drain_issue, out_free, handshake;
  logic [1:0]    occ;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  sum, rd_out;

  assign accept    = (state == ACCUM) && valid_i && !start;
  assign wr_en     = s1_valid && !start;
  assign handshake = valid_o && out_ready;
  assign out_free  = !valid_o || out_ready;

  // Beats already owed to the output side after this edge; a read is only
  // issued when its data is guaranteed a slot in out or prefetch.
  assign occ         = 2'(valid_o) + 2'(pf_valid) + 2'(rd_pend) - 2'(handshake);
  assign drain_issue = (state == DRAIN) && !rd_all && !start && (occ < 2'd2);

  assign rd_en   = accept || drain_issue;
  assign rd_addr = (state == ACCUM) ? wptr : rptr;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DW-1:0] a, b, r;
    logic signed [DW:0]   s;
    assign a = s1_data[gi*DW +: DW];
    assign b = s1_first ? '0 : rd_data[gi*DW +: DW];
    assign s = {a[DW-1], a} + {b[DW-1], b};
    always_comb begin
      r = s[DW-1:0];
      if (SAT && (s[DW] != s[DW-1]))
        r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    assign sum[gi*DW +: DW]    = r;
    assign rd_out[gi*DW +: DW] = (RELU && rd_data[gi*DW+DW-1]) ? '0 : rd_data[gi*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[s1_addr] <= sum;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = IDLE;
      ACCUM: if (accept && wptr == LAST_ADDR && chn == LAST_CHN) state_next = FLUSH;
      FLUSH: if (flush_cnt) state_next = DRAIN;
      DRAIN: if (handshake && last_o) state_next = DONE;
      DONE:  state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (start) state_next = ACCUM;
  end

  assign busy      = (state == ACCUM) || (state == FLUSH) || (state == DRAIN);
  assign conv_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      chn       <= '0;
      flush_cnt <= 1'b0;
      rd_all    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_data   <= '0;
      s1_addr   <= '0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      pf_valid  <= 1'b0;
      pf_data   <= '0;
      pf_addr   <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      addr_o    <= '0;
      last_o    <= 1'b0;
      err_o     <= 1'b0;
    end else if (start) begin
      wptr      <= '0;
      rptr      <= '0;
      chn       <= '0;
      flush_cnt <= 1'b0;
      rd_all    <= 1'b0;
      s1_valid  <= 1'b0;
      rd_pend   <= 1'b0;
      pf_valid  <= 1'b0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (valid_i && state != ACCUM) err_o <= 1'b1;

      s1_valid <= accept;
      if (accept) begin
        s1_data  <= data_i;
        s1_addr  <= wptr;
        s1_first <= (chn == '0);
        if (wptr == LAST_ADDR) begin
          wptr <= '0;
          chn  <= (chn == LAST_CHN) ? '0 : chn + CW'(1);
        end else begin
          wptr <= wptr + AW'(1);
        end
      end

      flush_cnt <= (state == FLUSH);

      rd_pend <= drain_issue;
      if (drain_issue) begin
        rd_addr_q <= rptr;
        if (rptr == LAST_ADDR) rd_all <= 1'b1;
        else                   rptr   <= rptr + AW'(1);
      end

      // Output register refills from prefetch first to keep address order.
      if (out_free) begin
        if (pf_valid) begin
          valid_o <= 1'b1;
          data_o  <= pf_data;
          addr_o  <= pf_addr;
          last_o  <= (pf_addr == LAST_ADDR);
        end else if (rd_pend) begin
          valid_o <= 1'b1;
          data_o  <= rd_out;
          addr_o  <= rd_addr_q;
          last_o  <= (rd_addr_q == LAST_ADDR);
        end else begin
          valid_o <= 1'b0;
          last_o  <= 1'b0;
        end
      end

      if (pf_valid) begin
        if (out_free) begin
          pf_valid <= rd_pend;
          pf_data  <= rd_out;
          pf_addr  <= rd_addr_q;
        end
      end else if (rd_pend && !out_free) begin
        pf_valid <= 1'b1;
        pf_data  <= rd_out;
        pf_addr  <= rd_addr_q;
      end
    end
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised bench for psum_accumulator: three instances (saturating, wrapping,
// saturating+RELU) share stimulus and are scored against an arithmetic model.
module tb_psum_accumulator;
  localparam int LANES = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NCHNL = 3;
  localparam int AW    = 2;
  localparam int W     = LANES * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          valid_i = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_i = '0;

  logic [W-1:0]  data_o, data_o_w, data_o_r;
  logic          valid_o, valid_o_w, valid_o_r;
  logic [AW-1:0] addr_o, addr_o_w, addr_o_r;
  logic          last_o, last_o_w, last_o_r;
  logic          busy, busy_w, busy_r;
  logic          conv_done, conv_done_w, conv_done_r;
  logic          err_o, err_o_w, err_o_r;

  int errors = 0;
  int checks = 0;

  int stim     [NCHNL][DEPTH][LANES];
  int exp_sat  [DEPTH][LANES];
  int exp_wrap [DEPTH][LANES];
  int exp_relu [DEPTH][LANES];

  always #5 clk = ~clk;

  psum_accumulator #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .NCHNL(NCHNL), .AW(AW),
                     .SAT(1'b1), .RELU(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_i(data_i), .valid_i(valid_i),
    .out_ready(out_ready), .data_o(data_o), .valid_o(valid_o), .addr_o(addr_o),
    .last_o(last_o), .busy(busy), .conv_done(conv_done), .err_o(err_o));

  psum_accumulator #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .NCHNL(NCHNL), .AW(AW),
                     .SAT(1'b0), .RELU(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .data_i(data_i), .valid_i(valid_i),
    .out_ready(out_ready), .data_o(data_o_w), .valid_o(valid_o_w), .addr_o(addr_o_w),
    .last_o(last_o_w), .busy(busy_w), .conv_done(conv_done_w), .err_o(err_o_w));

  psum_accumulator #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .NCHNL(NCHNL), .AW(AW),
                     .SAT(1'b1), .RELU(1'b1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .data_i(data_i), .valid_i(valid_i),
    .out_ready(out_ready), .data_o(data_o_r), .valid_o(valid_o_r), .addr_o(addr_o_r),
    .last_o(last_o_r), .busy(busy_r), .conv_done(conv_done_r), .err_o(err_o_r));

  // Signed 8-bit add, either clamped or reduced modulo 256.
  function automatic int fold(input int a, input int b, input bit sat);
    int s;
    s = a + b;
    if (sat) begin
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
    end else begin
      s = ((s + 128) & 255) - 128;
    end
    return s;
  endfunction

  function automatic void compute_model();
    for (int p = 0; p < DEPTH; p++)
      for (int l = 0; l < LANES; l++) begin
        int s, w;
        s = stim[0][p][l];
        w = stim[0][p][l];
        for (int c = 1; c < NCHNL; c++) begin
          s = fold(s, stim[c][p][l], 1'b1);
          w = fold(w, stim[c][p][l], 1'b0);
        end
        exp_sat[p][l]  = s;
        exp_wrap[p][l] = w;
        exp_relu[p][l] = (s < 0) ? 0 : s;
      end
  endfunction

  function automatic void fill_random();
    for (int c = 0; c < NCHNL; c++)
      for (int p = 0; p < DEPTH; p++)
        for (int l = 0; l < LANES; l++)
          stim[c][p][l] = int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_beats(input int n, input int bubble_pct);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 1000) begin
      if (int'($urandom_range(0, 99)) < bubble_pct) begin
        valid_i = 1'b0;
      end else begin
        valid_i = 1'b1;
        for (int l = 0; l < LANES; l++)
          data_i[l*DW +: DW] = DW'(stim[k / DEPTH][k % DEPTH][l]);
        k++;
      end
      @(negedge clk);
      guard++;
    end
    valid_i = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic drain_and_score(input int mode, input bit inject);
    int nxt = 0;
    int cyc = 0;
    bit stall = 1'b0;
    bit injected = 1'b0;
    logic [W-1:0]  pd, ev, ew, er;
    logic [AW-1:0] pa;
    logic          pl;
    pd = '0; pa = '0; pl = 1'b0;
    while (nxt < DEPTH && cyc < 200) begin
      valid_i = 1'b0;
      if (stall) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== pd || addr_o !== pa || last_o !== pl) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h a=%0d l=%b, need v=1 d=%h a=%0d l=%b",
                   valid_o, data_o, addr_o, last_o, pd, pa, pl);
        end
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject && !injected && valid_o === 1'b1) begin
        valid_i = 1'b1;
        data_i  = W'($urandom);
        injected = 1'b1;
      end
      if (valid_o === 1'b1 && out_ready) begin
        for (int l = 0; l < LANES; l++) begin
          ev[l*DW +: DW] = DW'(exp_sat[nxt][l]);
          ew[l*DW +: DW] = DW'(exp_wrap[nxt][l]);
          er[l*DW +: DW] = DW'(exp_relu[nxt][l]);
        end
        $display("beat addr=%0d data=%h wrap=%h relu=%h last=%b", addr_o, data_o, data_o_w, data_o_r, last_o);
        checks++;
        if (data_o !== ev) begin
          errors++;
          $display("FAIL data_sat: addr %0d got %h need %h", nxt, data_o, ev);
        end
        checks++;
        if (addr_o !== AW'(nxt)) begin
          errors++;
          $display("FAIL addr: got %0d need %0d", addr_o, nxt);
        end
        checks++;
        if (last_o !== (nxt == DEPTH - 1)) begin
          errors++;
          $display("FAIL last: addr %0d got %b need %b", nxt, last_o, nxt == DEPTH - 1);
        end
        checks++;
        if (valid_o_w !== 1'b1 || data_o_w !== ew) begin
          errors++;
          $display("FAIL data_wrap: addr %0d got v=%b %h need v=1 %h", nxt, valid_o_w, data_o_w, ew);
        end
        checks++;
        if (valid_o_r !== 1'b1 || data_o_r !== er) begin
          errors++;
          $display("FAIL data_relu: addr %0d got v=%b %h need v=1 %h", nxt, valid_o_r, data_o_r, er);
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_drain: got %b need 1", busy);
        end
        nxt++;
      end
      stall = (valid_o === 1'b1) && !out_ready;
      pd = data_o;
      pa = addr_o;
      pl = last_o;
      cyc++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nxt != DEPTH) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats need %0d", nxt, DEPTH);
    end
    checks++;
    if (conv_done !== 1'b1 || busy !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL done: got done=%b busy=%b valid=%b need 1 0 0", conv_done, busy, valid_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({data_o, valid_o, addr_o, last_o, busy, conv_done, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got d=%h v=%b a=%0d l=%b busy=%b done=%b err=%b need all 0",
               data_o, valid_o, addr_o, last_o, busy, conv_done, err_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || conv_done !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL idle: got busy=%b done=%b err=%b need 0 0 0", busy, conv_done, err_o);
    end
  endtask

  task automatic test_basic();
    for (int c = 0; c < NCHNL; c++)
      for (int p = 0; p < DEPTH; p++)
        for (int l = 0; l < LANES; l++)
          stim[c][p][l] = c + 1;
    compute_model();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || conv_done !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got busy=%b done=%b need 1 0", busy, conv_done);
    end
    drive_beats(NCHNL * DEPTH, 0);
    drain_and_score(0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int c = 0; c < NCHNL; c++)
      for (int p = 0; p < DEPTH; p++) begin
        stim[c][p][0] = 100;
        stim[c][p][1] = -100;
      end
    compute_model();
    pulse_start();
    drive_beats(NCHNL * DEPTH, 0);
    drain_and_score(0, 1'b0);
  endtask

  task automatic test_relu();
    for (int p = 0; p < DEPTH; p++) begin
      stim[0][p][0] = -1; stim[1][p][0] = -2; stim[2][p][0] = -2;
      stim[0][p][1] = 2;  stim[1][p][1] = 2;  stim[2][p][1] = 3;
    end
    compute_model();
    pulse_start();
    drive_beats(NCHNL * DEPTH, 0);
    drain_and_score(0, 1'b0);
  endtask

  task automatic test_gaps();
    for (int it = 0; it < 3; it++) begin
      fill_random();
      compute_model();
      pulse_start();
      drive_beats(NCHNL * DEPTH, 35);
      drain_and_score(2, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    compute_model();
    pulse_start();
    drive_beats(NCHNL * DEPTH, 0);
    drain_and_score(1, 1'b0);
  endtask

  task automatic test_restart();
    fill_random();
    pulse_start();
    drive_beats(6, 0);
    fill_random();
    compute_model();
    pulse_start();
    drive_beats(NCHNL * DEPTH, 0);
    drain_and_score(0, 1'b0);
  endtask

  task automatic test_error();
    valid_i = 1'b1;
    data_i  = W'($urandom);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL err_done: got err=%b valid=%b need 1 0", err_o, valid_o);
    end
    fill_random();
    compute_model();
    pulse_start();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b need 0", err_o);
    end
    drive_beats(NCHNL * DEPTH, 0);
    drain_and_score(1, 1'b1);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_drain: got %b need 1", err_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    int guard = 0;
    fill_random();
    pulse_start();
    drive_beats(NCHNL * DEPTH, 0);
    out_ready = 1'b0;
    while (valid_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: got %b need 1", valid_o);
    end
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_o, valid_o, addr_o, last_o, busy, conv_done, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got d=%h v=%b a=%0d l=%b busy=%b done=%b err=%b need all 0",
               data_o, valid_o, addr_o, last_o, busy, conv_done, err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b need 0 0", busy, valid_o);
    end
    fill_random();
    compute_model();
    pulse_start();
    drive_beats(NCHNL * DEPTH, 20);
    drain_and_score(2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_gaps();
    test_backpressure();
    test_restart();
    test_error();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
